// File: rtl/vxe_fifo_unpack.sv
// Read-side consumer for a first-word-fall-through FIFO: pops one wide word and
// emits it as RATIO narrow beats (low slice first) on a registered valid/ready stream.
module vxe_fifo_unpack #(
  parameter int OUT_WIDTH = 32,
  parameter int RATIO     = 2
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       srst,
  input  logic [OUT_WIDTH*RATIO-1:0] fifo_data,
  input  logic                       fifo_empty,
  output logic                       fifo_rd,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_rdy,
  output logic                       busy
);

  localparam int IN_WIDTH = OUT_WIDTH * RATIO;
  localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [IN_WIDTH-1:0]  r_w;
  logic                 r_wv;
  logic [IDX_W-1:0]     r_idx;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_last;
  logic                 r_out_valid;

  logic                 w_last;
  logic                 w_ld;
  logic                 w_rd;
  logic [OUT_WIDTH-1:0] w_beat;

  assign w_last = (r_idx == LAST_IDX);
  assign w_ld   = r_wv & (~r_out_valid | out_rdy);
  // Refill either into an empty word register or exactly when its last beat leaves.
  assign w_rd   = nrst & ~srst & ~fifo_empty & (~r_wv | (w_ld & w_last));

  always_comb begin
    w_beat = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (r_idx == IDX_W'(k)) w_beat = r_w[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_w         <= '0;
      r_wv        <= 1'b0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (srst) begin
      r_w         <= '0;
      r_wv        <= 1'b0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_rd) begin
        r_w   <= fifo_data;
        r_wv  <= 1'b1;
        r_idx <= '0;
      end else if (w_ld) begin
        if (w_last) begin
          r_idx <= '0;
          r_wv  <= 1'b0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end

      if (w_ld) begin
        r_out_data  <= w_beat;
        r_out_last  <= w_last;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_rdy) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign fifo_rd   = w_rd;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign busy      = r_wv | r_out_valid;

endmodule

// File: tb/tb_vxe_fifo_unpack.sv
// Bench for vxe_fifo_unpack: a RATIO=2 and a RATIO=1 instance fed from queue FIFO
// models; a monitor scores every handshaken beat against the expected-beat queues.
module tb_vxe_fifo_unpack;
  typedef struct packed { logic [31:0] d; logic l; } beat_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        srst = 1'b0;
  logic [63:0] a_fdata = '0;
  logic        a_fempty = 1'b1;
  logic        a_frd;
  logic [31:0] a_odata;
  logic        a_olast, a_ovalid, a_busy;
  logic        a_rdy = 1'b0;
  logic [31:0] b_fdata = '0;
  logic        b_fempty = 1'b1;
  logic        b_frd;
  logic [31:0] b_odata;
  logic        b_olast, b_ovalid, b_busy;
  logic        b_rdy = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] afq[$];
  logic [31:0] bfq[$];
  beat_t       ea[$];
  beat_t       eb[$];

  logic nrst_n = 1'b0, srst_n = 1'b0, a_rdy_n = 1'b0, b_rdy_n = 1'b0;
  logic a_rd_q = 1'b0, b_rd_q = 1'b0;

  vxe_fifo_unpack #(.OUT_WIDTH(32), .RATIO(2)) u_a (
    .clk(clk), .nrst(nrst), .srst(srst), .fifo_data(a_fdata), .fifo_empty(a_fempty),
    .fifo_rd(a_frd), .out_data(a_odata), .out_last(a_olast), .out_valid(a_ovalid),
    .out_rdy(a_rdy), .busy(a_busy));

  vxe_fifo_unpack #(.OUT_WIDTH(32), .RATIO(1)) u_b (
    .clk(clk), .nrst(nrst), .srst(srst), .fifo_data(b_fdata), .fifo_empty(b_fempty),
    .fifo_rd(b_frd), .out_data(b_odata), .out_last(b_olast), .out_valid(b_ovalid),
    .out_rdy(b_rdy), .busy(b_busy));

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected beats come straight from the word: slice k of OUT_WIDTH bits, last on top slice.
  task automatic push_a(input logic [63:0] w);
    afq.push_back(w);
    for (int k = 0; k < 2; k++) ea.push_back(beat_t'{w[k*32 +: 32], (k == 1)});
  endtask

  task automatic push_b(input logic [31:0] w);
    bfq.push_back(w);
    eb.push_back(beat_t'{w, 1'b1});
  endtask

  // One clock: apply the edge's effect on the FIFO models, then drive inputs at the negedge.
  task automatic cyc();
    logic [63:0] ta;
    logic [31:0] tb;
    @(negedge clk);
    if (srst) begin
      afq.delete();
      bfq.delete();
    end else begin
      if (a_rd_q && afq.size() > 0) ta = afq.pop_front();
      if (b_rd_q && bfq.size() > 0) tb = bfq.pop_front();
    end
    nrst  = nrst_n;
    srst  = srst_n;
    a_rdy = a_rdy_n;
    b_rdy = b_rdy_n;
    a_fempty = (afq.size() == 0);
    a_fdata  = a_fempty ? 64'h0 : afq[0];
    b_fempty = (bfq.size() == 0);
    b_fdata  = b_fempty ? 32'h0 : bfq[0];
    #1;
    a_rd_q = a_frd;
    b_rd_q = b_frd;
    chk("a_rd_on_empty", {63'h0, a_frd & a_fempty}, 64'h0);
    chk("b_rd_on_empty", {63'h0, b_frd & b_fempty}, 64'h0);
  endtask

  task automatic drain(input int budget);
    a_rdy_n = 1'b1;
    b_rdy_n = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (ea.size() == 0 && eb.size() == 0 && afq.size() == 0 && bfq.size() == 0 &&
          !a_busy && !b_busy) break;
      cyc();
    end
    chk("drain_done", {63'h0, (ea.size() == 0 && eb.size() == 0 && !a_busy && !b_busy)}, 64'h1);
  endtask

  // Monitor: samples mid-low-phase, after inputs have settled for the coming edge.
  initial begin : mon
    logic        pv_a, pl_a, ph_a, pv_b, pl_b, ph_b;
    logic [31:0] pd_a, pd_b;
    beat_t       e;
    pv_a = 0; pl_a = 0; ph_a = 0; pd_a = 0;
    pv_b = 0; pl_b = 0; ph_b = 0; pd_b = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!nrst || srst) begin
        if (srst) begin
          ea.delete();
          eb.delete();
        end
        pv_a = 0;
        pv_b = 0;
      end else begin
        if (pv_a && !ph_a) begin
          chk("a_hold_valid", {63'h0, a_ovalid}, 64'h1);
          chk("a_hold_data", {32'h0, a_odata}, {32'h0, pd_a});
          chk("a_hold_last", {63'h0, a_olast}, {63'h0, pl_a});
        end
        if (a_ovalid && a_rdy) begin
          chk("a_beat_expected", {63'h0, ea.size() > 0}, 64'h1);
          if (ea.size() > 0) begin
            e = ea.pop_front();
            chk("a_data", {32'h0, a_odata}, {32'h0, e.d});
            chk("a_last", {63'h0, a_olast}, {63'h0, e.l});
          end
        end
        pv_a = a_ovalid; pd_a = a_odata; pl_a = a_olast; ph_a = a_ovalid & a_rdy;

        if (pv_b && !ph_b) begin
          chk("b_hold_valid", {63'h0, b_ovalid}, 64'h1);
          chk("b_hold_data", {32'h0, b_odata}, {32'h0, pd_b});
        end
        if (b_ovalid && b_rdy) begin
          chk("b_beat_expected", {63'h0, eb.size() > 0}, 64'h1);
          if (eb.size() > 0) begin
            e = eb.pop_front();
            chk("b_data", {32'h0, b_odata}, {32'h0, e.d});
            chk("b_last", {63'h0, b_olast}, {63'h0, e.l});
          end
        end
        pv_b = b_ovalid; pd_b = b_odata; pl_b = b_olast; ph_b = b_ovalid & b_rdy;
      end
    end
  end

  initial begin : stim
    logic [63:0] w;
    int first, last, nv, nrd, b2b, hs;
    logic prev_rd;

    #1 nrst = 1'b0;
    // Reset with data waiting in the FIFO: nothing may move.
    push_a(64'h1111_2222_3333_4444);
    a_rdy_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("rst_a_frd", {63'h0, a_frd}, 64'h0);
      chk("rst_a_valid", {63'h0, a_ovalid}, 64'h0);
      chk("rst_a_data", {32'h0, a_odata}, 64'h0);
      chk("rst_a_last", {63'h0, a_olast}, 64'h0);
      chk("rst_a_busy", {63'h0, a_busy}, 64'h0);
      chk("rst_b_valid", {63'h0, b_ovalid}, 64'h0);
      chk("rst_b_busy", {63'h0, b_busy}, 64'h0);
    end

    // Single word latency after release: pop in T, beats in T+2/T+3, idle in T+4.
    nrst_n = 1'b1;
    cyc(); chk("T0_frd", {63'h0, a_frd}, 64'h1);
    cyc(); chk("T1_frd", {63'h0, a_frd}, 64'h0);
           chk("T1_valid", {63'h0, a_ovalid}, 64'h0);
           chk("T1_busy", {63'h0, a_busy}, 64'h1);
    cyc(); chk("T2_valid", {63'h0, a_ovalid}, 64'h1);
           chk("T2_data", {32'h0, a_odata}, 64'h3333_4444);
           chk("T2_last", {63'h0, a_olast}, 64'h0);
    cyc(); chk("T3_data", {32'h0, a_odata}, 64'h1111_2222);
           chk("T3_last", {63'h0, a_olast}, 64'h1);
           chk("T3_busy", {63'h0, a_busy}, 64'h1);
    cyc(); chk("T4_busy", {63'h0, a_busy}, 64'h0);
           chk("T4_valid", {63'h0, a_ovalid}, 64'h0);

    // Stream of five words, full throughput.
    for (int n = 1; n <= 5; n++) push_a({16'hBEEF, 16'(n), 16'hCAFE, 16'(n)});
    first = -1; last = -1; nv = 0; nrd = 0; b2b = 0; prev_rd = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (a_ovalid) begin
        if (first < 0) first = i;
        last = i;
        nv++;
      end
      if (a_frd) begin
        nrd++;
        if (prev_rd) b2b++;
      end
      prev_rd = a_frd;
    end
    chk("stream_beats", 64'(nv), 64'd10);
    chk("stream_span", 64'(last - first + 1), 64'd10);
    chk("stream_pops", 64'(nrd), 64'd5);
    chk("stream_pop_b2b", 64'(b2b), 64'd0);
    chk("stream_fifo_empty", 64'(afq.size()), 64'd0);

    // Backpressure after the third beat.
    for (int n = 1; n <= 5; n++) push_a({16'hBEEF, 16'(n), 16'hCAFE, 16'(n)});
    hs = 0;
    for (int i = 0; i < 40 && hs < 3; i++) begin
      cyc();
      if (a_ovalid && a_rdy) hs++;
    end
    chk("bp_reached_beat3", 64'(hs), 64'd3);
    a_rdy_n = 1'b0;
    repeat (3) begin
      cyc();
      chk("bp_frd", {63'h0, a_frd}, 64'h0);
      chk("bp_valid", {63'h0, a_ovalid}, 64'h1);
      chk("bp_data", {32'h0, a_odata}, 64'hBEEF_0002);
      chk("bp_last", {63'h0, a_olast}, 64'h1);
    end
    drain(100);

    // Flush mid-word (idx=1, beat 0 presented).
    w = {$urandom(), $urandom()}; push_a(w);
    w = {$urandom(), $urandom()}; push_a(w);
    cyc(); chk("fl_pop", {63'h0, a_frd}, 64'h1);
    cyc();
    srst_n = 1'b1; a_rdy_n = 1'b0;
    cyc(); chk("fl_pre_valid", {63'h0, a_ovalid}, 64'h1);
           chk("fl_srst_frd", {63'h0, a_frd}, 64'h0);
    srst_n = 1'b0;
    cyc(); chk("fl_valid", {63'h0, a_ovalid}, 64'h0);
           chk("fl_busy", {63'h0, a_busy}, 64'h0);
           chk("fl_data", {32'h0, a_odata}, 64'h0);
           chk("fl_last", {63'h0, a_olast}, 64'h0);
    push_a(64'h0123_4567_89AB_CDEF);
    w = {$urandom(), $urandom()}; push_a(w);
    drain(100);

    // RATIO=1: random ready, then sustained one word per cycle.
    for (int n = 1; n <= 4; n++) push_b({16'hCAFE, 16'(n)});
    for (int i = 0; i < 20; i++) begin
      b_rdy_n = ($urandom_range(1) == 1);
      cyc();
    end
    drain(100);
    for (int n = 5; n <= 8; n++) push_b({16'hCAFE, 16'(n)});
    b_rdy_n = 1'b1;
    first = -1; last = -1; nv = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (b_ovalid) begin
        if (first < 0) first = i;
        last = i;
        nv++;
      end
    end
    chk("r1_beats", 64'(nv), 64'd4);
    chk("r1_span", 64'(last - first + 1), 64'd4);

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        w = {$urandom(), $urandom()};
        push_a(w);
      end
      if ($urandom_range(2) == 0) push_b($urandom());
      a_rdy_n = ($urandom_range(3) != 0);
      b_rdy_n = ($urandom_range(1) == 1);
      cyc();
    end
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
